// File: rtl/bar_timer_pkg.sv
// Shared widths, time defaults, FSM encoding and time-arithmetic helpers
// for the bar timer controller.
package bar_timer_pkg;

    localparam int unsigned TIME_W       = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned DEF_MIN_TIME = 1;
    localparam int unsigned DEF_MAX_TIME = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Saturating clamp of a switch value into the legal round-time window.
    function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                     input logic [TIME_W-1:0] lo,
                                                     input logic [TIME_W-1:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One-step shorter round time that never drops below the floor.
    function automatic logic [TIME_W-1:0] dec_time(input logic [TIME_W-1:0] t,
                                                   input logic [TIME_W-1:0] lo);
        return (t > lo) ? t - TIME_W'(1) : lo;
    endfunction

endpackage

// File: rtl/bar_timer_controller_if.sv
// Switch/button/timer signals between the game logic and the bar timer controller.
interface bar_timer_controller_if;
    import bar_timer_pkg::*;

    logic [TIME_W-1:0] levelSw;
    logic              start;
    logic              hit;
    logic              timeout;
    logic [TIME_W-1:0] startTime;
    logic              enable;
    logic              roundDone;
    logic              gameOver;
    logic [CNT_W-1:0]  roundCount;
    logic              busy;

    modport master (
        output levelSw, start, hit, timeout,
        input  startTime, enable, roundDone, gameOver, roundCount, busy
    );

    modport slave (
        input  levelSw, start, hit, timeout,
        output startTime, enable, roundDone, gameOver, roundCount, busy
    );

endinterface

// File: rtl/bar_start_edge.sv
// Registered rising-edge detector for the start button level.
module bar_start_edge (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic rise
);

    logic hist;

    // History resets high so a button already held at reset never counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
            rise <= 1'b0;
        end else begin
            hist <= start;
            rise <= start & ~hist;
        end
    end

endmodule

// File: rtl/bar_timer_controller.sv
// Round sequencer for the LED bar timer: loads the round time, runs the timer,
// shortens the time after every expiry and aborts on a hit.
module bar_timer_controller
    import bar_timer_pkg::*;
#(
    parameter int unsigned MIN_TIME   = DEF_MIN_TIME,
    parameter int unsigned MAX_TIME   = DEF_MAX_TIME,
    parameter int unsigned MAX_ROUNDS = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    bar_timer_controller_if.slave  bus
);

    localparam logic [TIME_W-1:0] MIN_T = TIME_W'(MIN_TIME);
    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [CNT_W-1:0]  MAX_R = CNT_W'(MAX_ROUNDS);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              start_rise;
    logic              launch_c;
    logic              abort_c;
    logic              expire_c;

    logic [TIME_W-1:0] start_time;
    logic [CNT_W-1:0]  round_count;
    logic              enable_q;
    logic              round_done;
    logic              game_over;
    logic              busy_q;

    bar_start_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .start (bus.start),
        .rise  (start_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state; hit outranks timeout in RUN.
    always_comb begin
        state_nx = state;
        launch_c = 1'b0;
        abort_c  = 1'b0;
        expire_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    launch_c = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.hit) begin
                    abort_c  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.hit) begin
                    abort_c  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (bus.timeout) begin
                    expire_c = 1'b1;
                    state_nx = ST_EXPIRED;
                end
            end
            ST_EXPIRED: state_nx = ST_LOAD;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_time  <= MIN_T;
            round_count <= '0;
            enable_q    <= 1'b0;
            round_done  <= 1'b0;
            game_over   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            enable_q   <= (state_nx == ST_RUN);
            busy_q     <= (state_nx != ST_IDLE);
            round_done <= expire_c;
            game_over  <= abort_c;
            if (launch_c) begin
                start_time  <= clamp_time(bus.levelSw, MIN_T, MAX_T);
                round_count <= '0;
            end else begin
                if (state == ST_EXPIRED)
                    start_time <= dec_time(start_time, MIN_T);
                if (expire_c && (round_count != MAX_R))
                    round_count <= round_count + CNT_W'(1);
            end
        end
    end

    assign bus.startTime  = start_time;
    assign bus.enable     = enable_q;
    assign bus.roundDone  = round_done;
    assign bus.gameOver   = game_over;
    assign bus.roundCount = round_count;
    assign bus.busy       = busy_q;

endmodule
